instruction_sequencer: RTL
==========================

# instruction_sequencer

Program sequencer directly upstream of `instruction_decoder`. It holds a small writable program of 9-bit instructions and issues them one at a time on `instruct`, in the decoder's field layout: [2:0] input select, [5:3] output select, [8:6] opcode. It supports free-run with a programmable hold time per instruction, single-step, and looping, so the decoder can be driven without a testbench hand-sequencing `instruct`.

## Interface
Parameters:
- `DEPTH`, 16: program memory entries, a power of two.
- `AW`, $clog2(DEPTH): address width.
- `HOLD`, 1: cycles each instruction is held in free-run, at least 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: program write strobe.
- `wr_addr` in AW: write address.
- `wr_data` in 9: instruction to store.
- `prog_len` in AW+1: number of instructions to run, sampled at start. Values above DEPTH clamp to DEPTH.
- `start` in 1: begin a run. Level-sampled and honoured only in IDLE.
- `step_mode` in 1: 0 selects free-run, 1 selects single-step. Sampled at start.
- `step` in 1: in single-step, each cycle it is high issues the next instruction.
- `loop` in 1: 1 wraps the program counter to 0 after the last entry. Evaluated live.
- `stop` in 1: abort the run.
- `instruct` out 9: instruction to the decoder. Registered; holds its last value.
- `instr_valid` out 1: one-cycle pulse on each new issue.
- `pc` out AW: index of the instruction currently on `instruct`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when a non-loop run completes.

## Operation
- Reset values: all outputs 0, state IDLE, hold counter 0. All memory entries clear to 9'h000.
- States:
  - IDLE to RUN on `start` with clamped `prog_len` != 0. `start` with `prog_len`=0 is ignored.
  - RUN to IDLE on `stop`, or on completion when `loop`=0.
- Writes take effect only in IDLE. `wr_en` while busy is ignored.
- Free-run:
  - Instruction i is issued, `hold_cnt` loads HOLD-1 and `instr_valid` pulses.
  - The next instruction issues when `hold_cnt` reaches 0.
  - After the last entry's hold expires: with `loop`=1, `pc` wraps to 0 and issues again; with `loop`=0, `done` pulses and the block returns to IDLE.
- Single-step:
  - HOLD is ignored.
  - Each `step`-high cycle in RUN issues the next entry.
  - The first `step` after the last entry either wraps (`loop`=1) or produces `done` (`loop`=0). That `step` issues nothing.
  - `step` in IDLE is ignored.
- `stop` has priority over issue and completion. It takes effect next edge: IDLE, `busy`=0, no `done`, and `instruct` and `pc` hold.
- `start` while busy is ignored. `start` and `stop` high together in IDLE: `stop` wins, so the block stays in IDLE.
- `instruct` is never cleared except by reset, so the decoder keeps seeing the last instruction.

## Timing
- Free-run start: `start` is sampled at edge k. At edge k+1, `busy`=1, `instruct`=mem[0], `instr_valid`=1, `pc`=0.
- Entry i appears at edge k+1+i·HOLD.
- Non-loop completion: at edge k+1+len·HOLD, `done`=1 and `busy`=0. `done` falls the following edge.
- Single-step: `step` is sampled at edge s and the issue happens at edge s+1. The first issue needs a `step` after start, so `start` alone issues nothing.
- Back-to-back runs: `start` is accepted in the cycle where `done`=1, because the state is already IDLE.
- `rst_n` falling clears all state immediately, without waiting for a clock edge.

## Structure
- Package `seq_pkg` holds:
  - `INSTR_W`=9 and the field localparams `SEL_IN_LSB`=0, `SEL_OUT_LSB`=3, `OP_LSB`=6, each field 3 bits wide.
  - `typedef enum logic {IDLE, RUN} seq_state_t`.
- Sub-module `instr_mem`: DEPTH×9 register file with synchronous write, asynchronous read and async-clear on `rst_n`.
- The top level contains the FSM, `pc`, `hold_cnt` and the output registers.

## Test plan
All scenarios use program mem = {9'h1F4, 9'h134, 9'h0DC}: (op7,out6,in4), (op4,out6,in4) and (op3,out3,in4).
- **Free-run, HOLD=1, `prog_len`=3, `loop`=0.** `start` at edge k → `instruct` = 1F4, 134, 0DC at edges k+1..k+3, each with `instr_valid`. `done`=1 at k+4, `busy`=0 at k+4, `instruct` stays 0DC.
- **HOLD=4, same program.** Issues at k+1, k+5, k+9. `instr_valid` high on those edges only. `done` at k+13.
- **`loop`=1, `prog_len`=2, HOLD=1.** Sequence 1F4, 134, 1F4, 134… Assert `stop` → IDLE next edge, `done` never pulses, `instruct` holds its value.
- **`step_mode`=1.** Three `step` pulses 10 cycles apart issue 1F4, 134, 0DC, each one edge after its step. A 4th step → `done`. Extra `step` in IDLE → no change.
- **Reset mid-run.** Drop `rst_n` mid-run → outputs 0 immediately, no clock needed. A fresh run with `prog_len`=3 issues 000 three times, because memory was cleared.
- **Ignored requests.** `start` with `prog_len`=0 → no `busy`. `wr_en` during RUN → memory unchanged, verified on the next run. `prog_len`=31 with DEPTH=16 → 16 issues, then `done`.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: instruction field layout and FSM states.
package seq_pkg;

    localparam int INSTR_W     = 9;
    localparam int FIELD_W     = 3;
    localparam int SEL_IN_LSB  = 0;
    localparam int SEL_OUT_LSB = 3;
    localparam int OP_LSB      = 6;

    typedef enum logic {IDLE, RUN} seq_state_t;

endpackage

// File: rtl/instr_mem.sv
// Program store: one register per entry, synchronous write, asynchronous read,
// cleared to zero by reset.
module instr_mem
    import seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] entry [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [INSTR_W-1:0] data_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    data_reg <= wr_data;
                end
            end

            assign entry[gi] = data_reg;
        end
    endgenerate

    assign rd_data = entry[rd_addr];

endmodule

// File: rtl/instruction_sequencer.sv
// Issues a stored program to instruction_decoder one instruction at a time,
// in free-run (HOLD cycles per entry) or single-step, optionally looping.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int HOLD  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW:0]        prog_len,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic               loop,
    input  logic               stop,
    output logic [INSTR_W-1:0] instruct,
    output logic               instr_valid,
    output logic [AW-1:0]      pc,
    output logic               busy,
    output logic               done
);

    localparam int            HW          = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD - 1);
    localparam logic [AW:0]   DEPTH_L     = (AW + 1)'(DEPTH);

    seq_state_t         state_reg;
    logic [AW:0]        len_reg;
    logic [AW:0]        cnt_reg;        // entries issued in the current pass
    logic [HW-1:0]      hold_cnt_reg;
    logic               step_mode_reg;
    logic [INSTR_W-1:0] instruct_reg;
    logic [AW-1:0]      pc_reg;
    logic               instr_valid_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [AW:0]        len_clamped;
    logic               at_end;
    logic               advance;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_data;

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && (state_reg == IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign at_end      = (cnt_reg >= len_reg);

    always_comb begin
        advance = 1'b0;
        rd_addr = cnt_reg[AW-1:0];
        // Entry 0 is what a fresh run or a loop wrap needs to see.
        if (state_reg == IDLE || at_end) begin
            rd_addr = '0;
        end
        if (state_reg == RUN && !stop) begin
            advance = step_mode_reg ? step : (hold_cnt_reg == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            len_reg         <= '0;
            cnt_reg         <= '0;
            hold_cnt_reg    <= '0;
            step_mode_reg   <= 1'b0;
            instruct_reg    <= '0;
            pc_reg          <= '0;
            instr_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            instr_valid_reg <= 1'b0;
            done_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !stop && (len_clamped != '0)) begin
                        state_reg     <= RUN;
                        busy_reg      <= 1'b1;
                        len_reg       <= len_clamped;
                        step_mode_reg <= step_mode;
                        cnt_reg       <= '0;
                        if (!step_mode) begin
                            instruct_reg    <= rd_data;
                            pc_reg          <= '0;
                            instr_valid_reg <= 1'b1;
                            hold_cnt_reg    <= HOLD_RELOAD;
                            cnt_reg         <= (AW + 1)'(1);
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (advance) begin
                        if (!at_end || (loop && !step_mode_reg)) begin
                            instruct_reg    <= rd_data;
                            pc_reg          <= rd_addr;
                            instr_valid_reg <= 1'b1;
                            hold_cnt_reg    <= HOLD_RELOAD;
                            cnt_reg         <= {1'b0, rd_addr} + (AW + 1)'(1);
                        end else if (loop) begin
                            // Single-step wrap consumes the step without issuing.
                            cnt_reg <= '0;
                        end else begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else if (!step_mode_reg) begin
                        hold_cnt_reg <= hold_cnt_reg - HW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign instruct    = instruct_reg;
    assign instr_valid = instr_valid_reg;
    assign pc          = pc_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;

endmodule
